bf_io_bridge: RTL and testbench

Host-side I/O bridge for the BF core: buffers host input bytes in an input FIFO and hands them to the core's `,` interface, and captures the core's `.` output bytes into an output FIFO drained by the host. The bridge sits between the BF core's in/out ports and a host valid/ready byte stream. It generates the core's `enable` so the core stalls while the output FIFO is full.

---
 rtl/bf_io_bridge.sv | 106 ++++++++++
 tb/tb_bf_io_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bf_io_bridge.sv
// Host-side byte bridge for the BF core: input FIFO feeding the core's ',' port and
// output FIFO capturing '.' bytes. Optional sticky end-of-input support via BF_IO_EOF_EN.
module bf_io_bridge #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [7:0]                   host_in_data,
  input  logic                         host_in_valid,
  output logic                         host_in_ready,
  input  logic                         host_in_eof,
  output logic [7:0]                   core_in_val,
  output logic                         core_in_valid,
  input  logic                         core_in_reading,
  input  logic [7:0]                   core_out_val,
  input  logic                         core_out_enable,
  output logic                         core_enable,
  output logic [7:0]                   host_out_data,
  output logic                         host_out_valid,
  input  logic                         host_out_ready,
  output logic [$clog2(IN_DEPTH):0]    in_level,
  output logic [$clog2(OUT_DEPTH):0]   out_level
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_ONE  = 1;
  localparam logic [OAW:0] OUT_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IAW:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OAW:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [7:0]   in_mem_q  [IN_DEPTH];
  logic [7:0]   out_mem_q [OUT_DEPTH];
  logic         eof_seen_q, eof_seen_d;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) &&
                     (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) &&
                     (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);

  assign in_level  = in_wr_q - in_rd_q;
  assign out_level = out_wr_q - out_rd_q;

`ifdef BF_IO_EOF_EN
  assign eof_seen_d = eof_seen_q | host_in_eof;
`else
  logic unused_eof;
  assign unused_eof = host_in_eof;
  assign eof_seen_d = 1'b0;
`endif

  // After EOF the core sees an endless supply of 0x00 once buffered bytes are gone.
  assign host_in_ready = !in_full && !eof_seen_q;
  assign core_in_valid = !in_empty || eof_seen_q;
  assign core_in_val   = in_empty ? 8'h00 : in_mem_q[in_rd_q[IAW-1:0]];

  assign core_enable    = !out_full;
  assign host_out_valid = !out_empty;
  assign host_out_data  = out_empty ? 8'h00 : out_mem_q[out_rd_q[OAW-1:0]];

  assign in_push  = host_in_valid && host_in_ready;
  assign in_pop   = core_in_reading && !in_empty;
  assign out_push = core_out_enable && core_enable;
  assign out_pop  = host_out_valid && host_out_ready;

  always_comb begin
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    out_wr_d = out_wr_q;
    out_rd_d = out_rd_q;
    if (in_push)  in_wr_d  = in_wr_q + IN_ONE;
    if (in_pop)   in_rd_d  = in_rd_q + IN_ONE;
    if (out_push) out_wr_d = out_wr_q + OUT_ONE;
    if (out_pop)  out_rd_d = out_rd_q + OUT_ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      eof_seen_q <= 1'b0;
    end else begin
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      eof_seen_q <= eof_seen_d;
    end
  end

  // Storage needs no reset: reads are masked to 0x00 while a FIFO is empty.
  always_ff @(posedge clock) begin
    if (in_push)  in_mem_q[in_wr_q[IAW-1:0]]   <= host_in_data;
    if (out_push) out_mem_q[out_wr_q[OAW-1:0]] <= core_out_val;
  end

endmodule

// File: tb/tb_bf_io_bridge.sv
// Self-checking bench for bf_io_bridge: directed vector table, corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_bf_io_bridge;

  localparam int IN_D  = 16;
  localparam int OUT_D = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] host_in_data;
  logic       host_in_valid;
  logic       host_in_ready;
  logic       host_in_eof;
  logic [7:0] core_in_val;
  logic       core_in_valid;
  logic       core_in_reading;
  logic [7:0] core_out_val;
  logic       core_out_enable;
  logic       core_enable;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready;
  logic [4:0] in_level;
  logic [4:0] out_level;

  bf_io_bridge #(.IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .host_in_eof(host_in_eof),
    .core_in_val(core_in_val), .core_in_valid(core_in_valid),
    .core_in_reading(core_in_reading),
    .core_out_val(core_out_val), .core_out_enable(core_out_enable),
    .core_enable(core_enable),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .in_level(in_level), .out_level(out_level)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  bit         eof_m = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_state();
    int il, ol;
    il = in_q.size();
    ol = out_q.size();
    check("in_level", int'(in_level), il);
    check("out_level", int'(out_level), ol);
    check("host_in_ready", int'(host_in_ready), int'((il < IN_D) && !eof_m));
    check("core_in_valid", int'(core_in_valid), int'((il > 0) || eof_m));
    check("core_in_val", int'(core_in_val), (il > 0) ? int'(in_q[0]) : 0);
    check("core_enable", int'(core_enable), int'(ol < OUT_D));
    check("host_out_valid", int'(host_out_valid), int'(ol > 0));
    check("host_out_data", int'(host_out_data), (ol > 0) ? int'(out_q[0]) : 0);
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic cyc(input logic hiv, input logic [7:0] hid, input logic eof,
                     input logic cir, input logic coe, input logic [7:0] cov,
                     input logic hor);
    bit ir, ce, ipop, opop;
    host_in_valid = hiv; host_in_data = hid; host_in_eof = eof;
    core_in_reading = cir; core_out_enable = coe; core_out_val = cov;
    host_out_ready = hor;
    ir   = (in_q.size() < IN_D) && !eof_m;
    ce   = out_q.size() < OUT_D;
    ipop = cir && (in_q.size() > 0);
    opop = hor && (out_q.size() > 0);
    if (ipop) void'(in_q.pop_front());
    if (hiv && ir) in_q.push_back(hid);
    if (opop) void'(out_q.pop_front());
    if (coe && ce) out_q.push_back(cov);
`ifdef BF_IO_EOF_EN
    if (eof) eof_m = 1;
`endif
    @(posedge clock); #1;
    check_state();
  endtask

  task automatic idle_inputs();
    host_in_valid = 0; host_in_data = 0; host_in_eof = 0;
    core_in_reading = 0; core_out_enable = 0; core_out_val = 0;
    host_out_ready = 0;
  endtask

  typedef struct {
    logic hiv; logic [7:0] hid; logic cir; logic coe; logic [7:0] cov; logic hor;
    int e_il; int e_ol; logic e_civ; logic [7:0] e_cval;
    logic e_hov; logic [7:0] e_hod; logic e_hir; logic e_cen;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 8'h41, 0, 0, 8'h00, 0, 1, 0, 1, 8'h41, 0, 8'h00, 1, 1};
    vecs[1] = '{1, 8'h42, 0, 0, 8'h00, 0, 2, 0, 1, 8'h41, 0, 8'h00, 1, 1};
    vecs[2] = '{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 1, 8'h42, 0, 8'h00, 1, 1};
    vecs[3] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1};
    vecs[4] = '{0, 8'h00, 0, 1, 8'h55, 0, 0, 1, 0, 8'h00, 1, 8'h55, 1, 1};
    vecs[5] = '{0, 8'h00, 0, 1, 8'h66, 1, 0, 1, 0, 8'h00, 1, 8'h66, 1, 1};
    vecs[6] = '{0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1};
    vecs[7] = '{1, 8'h99, 0, 1, 8'h11, 0, 1, 1, 1, 8'h99, 1, 8'h11, 1, 1};
    vecs[8] = '{0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1};

    idle_inputs();
    reset_n = 0;
    #12;
    check("rst_in_level", int'(in_level), 0);
    check("rst_core_enable", int'(core_enable), 1);
    reset_n = 1;
    @(posedge clock); #1;

    // Directed vector table (input path, output path, simultaneous push/pop).
    for (int i = 0; i < 9; i++) begin
      host_in_valid = vecs[i].hiv; host_in_data = vecs[i].hid;
      core_in_reading = vecs[i].cir; core_out_enable = vecs[i].coe;
      core_out_val = vecs[i].cov; host_out_ready = vecs[i].hor;
      @(posedge clock); #1;
      check($sformatf("vec%0d_in_level", i), int'(in_level), vecs[i].e_il);
      check($sformatf("vec%0d_out_level", i), int'(out_level), vecs[i].e_ol);
      check($sformatf("vec%0d_core_in_valid", i), int'(core_in_valid), int'(vecs[i].e_civ));
      check($sformatf("vec%0d_core_in_val", i), int'(core_in_val), int'(vecs[i].e_cval));
      check($sformatf("vec%0d_host_out_valid", i), int'(host_out_valid), int'(vecs[i].e_hov));
      check($sformatf("vec%0d_host_out_data", i), int'(host_out_data), int'(vecs[i].e_hod));
      check($sformatf("vec%0d_host_in_ready", i), int'(host_in_ready), int'(vecs[i].e_hir));
      check($sformatf("vec%0d_core_enable", i), int'(core_enable), int'(vecs[i].e_cen));
    end
    idle_inputs();

    // Input full, then a refused push alongside a pop.
    for (int i = 0; i < 16; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 0, 0, 0);
    check("full_in_level", int'(in_level), 16);
    check("full_host_in_ready", int'(host_in_ready), 0);
    cyc(1, 8'hEE, 0, 1, 0, 0, 0);
    check("full_push_refused_level", int'(in_level), 15);
    check("full_head_after_pop", int'(core_in_val), 8'hA1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    check("full_drained", int'(core_in_valid), 0);

    // Output backpressure and in-order drain.
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 8'(i), 0);
    check("bp_out_level", int'(out_level), 16);
    check("bp_core_enable", int'(core_enable), 0);
    cyc(0, 0, 0, 0, 1, 8'hAA, 0);
    check("bp_not_captured", int'(out_level), 16);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("bp_enable_back", int'(core_enable), 1);
    for (int i = 1; i < 16; i++) begin
      check("bp_drain_order", int'(host_out_data), i);
      cyc(0, 0, 0, 0, 0, 0, 1);
    end
    check("bp_drained", int'(host_out_valid), 0);

    // Concurrent push/pop on both FIFOs with wrap-around.
    for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0, 0, 1, 8'(8'h80 + i), 0);
    for (int i = 4; i < 44; i++) cyc(1, 8'(i), 0, 1, 1, 8'(8'h80 + i), 1);
    check("conc_in_level", int'(in_level), 4);
    check("conc_out_level", int'(out_level), 4);
    check("conc_in_head", int'(core_in_val), 40);
    check("conc_out_head", int'(host_out_data), 8'h80 + 40);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0));

    // Asynchronous reset mid-traffic with 3 bytes buffered on each side.
    for (int i = 0; i < 3; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 1, 8'h20 + 8'(i), 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 1, 8'h20 + 8'(i), 0);
    check("pre_rst_in_level", int'(in_level), 3);
    check("pre_rst_out_level", int'(out_level), 3);
    idle_inputs();
    #2 reset_n = 0;
    #1;
    in_q.delete(); out_q.delete(); eof_m = 0;
    check_state();
    @(posedge clock); #1;
    check_state();
    reset_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // End-of-input behaviour.
    cyc(1, 8'h07, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
`ifdef BF_IO_EOF_EN
    check("eof_host_in_ready", int'(host_in_ready), 0);
    check("eof_first_byte", int'(core_in_val), 8'h07);
    cyc(1, 8'h33, 0, 1, 0, 0, 0);
    check("eof_zero_valid", int'(core_in_valid), 1);
    check("eof_zero_val", int'(core_in_val), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("eof_zero_again", int'(core_in_val), 0);
    check("eof_level", int'(in_level), 0);
`else
    check("noeof_host_in_ready", int'(host_in_ready), 1);
    check("noeof_byte", int'(core_in_val), 8'h07);
    cyc(0, 0, 1, 1, 0, 0, 0);
    check("noeof_valid_low", int'(core_in_valid), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
